alarma_multizona: RTL and testbench
===================================

# alarma_multizona

Parametrised multi-zone intrusion/fire alarm controller, next generation of the single-zone security FSM. Adds N maskable zones, timed exit and entry delays, a failed-password attempt counter and a latched record of triggering zones. It sits between the debounced sensor/keypad front end and the siren/light drivers.

## Interface

Parameters:

- N_ZONAS, 4, number of zones (1..16).
- T_SALIDA, 8, exit-delay length in clk cycles (>=1).
- T_ENTRADA, 16, entry-delay length in clk cycles (>=1).
- MAX_INTENTOS, 2, wrong-password pulses tolerated in ENTRADA before alarm (>=1).

Ports:

- clk  in  1  system clock; all state changes on posedge.
- rst  in  1  asynchronous, active-high reset.
- humo  in  1  smoke detector, level.
- armar  in  1  arm request, level.
- pw_ok  in  1  one-cycle pulse, correct password entered.
- pw_err  in  1  one-cycle pulse, wrong password entered.
- zona_mask  in  N_ZONAS  1 = zone enabled.
- sens_int  in  N_ZONAS  per-zone window/motion sensors, level.
- sens_puerta  in  N_ZONAS  per-zone door sensors, level.
- alarma_incendio  out  1  fire siren.
- luces  out  1  warning lights.
- alarma_robo  out  1  burglary siren.
- armado  out  1  system armed.
- zona_disparo  out  N_ZONAS  latched zones that caused ENTRADA/ROBO.
- estado  out  3  current state code.

## Operation

- States/codes: DESARMADO 000, SALIDA 101, ARMADO 111, ENTRADA 011, ROBO 010, INCENDIO 001.
- Masked inputs: int_m = sens_int & zona_mask, pta_m = sens_puerta & zona_mask.
- humo=1 in any state except INCENDIO -> INCENDIO (highest priority).
- DESARMADO: armar -> SALIDA, load cnt = T_SALIDA-1; pw_ok/pw_err ignored.
- SALIDA: pw_ok -> DESARMADO; else cnt==0 -> ARMADO; else cnt-1. Sensors ignored.
- ARMADO: |int_m -> ROBO; else |pta_m -> ENTRADA, load cnt = T_ENTRADA-1, intentos = 0. Intrusion beats door.
- ENTRADA, in priority order: |int_m -> ROBO; pw_err with intentos==MAX_INTENTOS-1 -> ROBO; pw_err -> intentos+1, stay; pw_ok -> DESARMADO; cnt==0 -> ROBO; else cnt-1.
- pw_ok and pw_err in the same cycle: treated as pw_err (fail-safe).
- ROBO: pw_ok -> DESARMADO; otherwise stay.
- INCENDIO: pw_ok and humo==0 -> DESARMADO; otherwise stay.
- zona_disparo: in ARMADO/ENTRADA/ROBO, OR-accumulates int_m|pta_m on each transition into or cycle spent in ENTRADA/ROBO. Cleared on entry to DESARMADO. Held in INCENDIO.
- cnt width = $clog2(max(T_SALIDA,T_ENTRADA)+1). intentos width = $clog2(MAX_INTENTOS+1). No wrap: cnt never decrements below 0.
- Outputs are a decode of the registered state only; there are no combinational input-to-output paths.
  - alarma_incendio = INCENDIO.
  - alarma_robo = ROBO.
  - luces = SALIDA|ENTRADA|ROBO|INCENDIO.
  - armado = ARMADO|ENTRADA.

## Timing

- Reset: state DESARMADO, cnt=0, intentos=0, zona_disparo=0. All outputs 0, estado=000. Reset asserted mid-operation aborts immediately, asynchronously.
- Every transition takes effect at the posedge after the causing input is sampled. Outputs change in the same cycle as estado.
- SALIDA lasts exactly T_SALIDA cycles without pw_ok. ENTRADA lasts exactly T_ENTRADA cycles without a password.
- pw_ok sampled on the last ENTRADA cycle (cnt==0) still disarms.
- Level inputs held high do not retrigger after return to DESARMADO. armar held high re-enters SALIDA on the next cycle (intended).

## Test plan

- Arm, N_ZONAS=4, T_SALIDA=8: armar=1 for 1 cycle -> luces=1 for 8 cycles, then estado=111, armado=1, luces=0.
- Entry then disarm: armed, sens_puerta=4'b0100 for 1 cycle, pw_ok at cycle 5 of ENTRADA -> DESARMADO, zona_disparo is 4'b0100 during ENTRADA, then 0.
- Entry timeout, T_ENTRADA=16: door on zone 0, no password -> alarma_robo=1 exactly 16 cycles after ENTRADA entry, zona_disparo=4'b0001.
- Attempts, MAX_INTENTOS=2: in ENTRADA, pw_err, then pw_err -> ROBO on the edge after the second pulse. A simultaneous pw_ok+pw_err counts as an error.
- Masking: zona_mask=4'b1110, sens_int=4'b0001 while armed -> stays ARMADO. sens_int=4'b1000 -> ROBO next edge.
- Fire priority and reset: humo=1 in ROBO -> INCENDIO, io=1, luces=1. pw_ok with humo=1 -> stays. humo=0 + pw_ok -> DESARMADO. rst pulse mid-SALIDA -> all outputs 0 immediately.

Source files
------------

// File: rtl/alarma_multizona.sv
// Multi-zone intrusion/fire alarm controller: masked zones, timed exit/entry
// delays, wrong-password attempt limit and a latched record of triggering zones.
module alarma_multizona #(
  parameter int N_ZONAS      = 4,
  parameter int T_SALIDA     = 8,
  parameter int T_ENTRADA    = 16,
  parameter int MAX_INTENTOS = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               humo,
  input  logic               armar,
  input  logic               pw_ok,
  input  logic               pw_err,
  input  logic [N_ZONAS-1:0] zona_mask,
  input  logic [N_ZONAS-1:0] sens_int,
  input  logic [N_ZONAS-1:0] sens_puerta,
  output logic               alarma_incendio,
  output logic               luces,
  output logic               alarma_robo,
  output logic               armado,
  output logic [N_ZONAS-1:0] zona_disparo,
  output logic [2:0]         estado
);

  // state     | meaning
  // DESARMADO | idle, waiting for armar
  // SALIDA    | exit delay running, pw_ok cancels
  // ARMADO    | armed, watching masked sensors
  // ENTRADA   | entry delay running, password expected
  // ROBO      | burglary alarm, pw_ok clears
  // INCENDIO  | fire alarm, pw_ok with no smoke clears
  typedef enum logic [2:0] {
    S_DESARMADO = 3'b000,
    S_SALIDA    = 3'b101,
    S_ARMADO    = 3'b111,
    S_ENTRADA   = 3'b011,
    S_ROBO      = 3'b010,
    S_INCENDIO  = 3'b001
  } estado_t;

  localparam int TMAX = (T_SALIDA > T_ENTRADA) ? T_SALIDA : T_ENTRADA;
  localparam int CW   = $clog2(TMAX + 1);
  localparam int IW   = $clog2(MAX_INTENTOS + 1);

  estado_t              state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        intentos_q, intentos_d;
  logic [N_ZONAS-1:0]   zona_q, zona_d;
  logic                 incendio_q, luces_q, robo_q, armado_q;

  logic [N_ZONAS-1:0]   int_m, pta_m;
  logic                 pw_ok_v;

  assign int_m   = sens_int & zona_mask;
  assign pta_m   = sens_puerta & zona_mask;
  // A simultaneous ok+err is treated as an error, so ok only counts alone.
  assign pw_ok_v = pw_ok & ~pw_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    intentos_d = intentos_q;
    zona_d     = zona_q;

    if (humo && state_q != S_INCENDIO) begin
      state_d = S_INCENDIO;
    end else begin
      case (state_q)
        S_DESARMADO: begin
          if (armar) begin
            state_d = S_SALIDA;
            cnt_d   = CW'(T_SALIDA - 1);
          end
        end
        S_SALIDA: begin
          if (pw_ok_v)            state_d = S_DESARMADO;
          else if (cnt_q == '0)   state_d = S_ARMADO;
          else                    cnt_d   = cnt_q - 1'b1;
        end
        S_ARMADO: begin
          if (|int_m) begin
            state_d = S_ROBO;
          end else if (|pta_m) begin
            state_d    = S_ENTRADA;
            cnt_d      = CW'(T_ENTRADA - 1);
            intentos_d = '0;
          end
        end
        S_ENTRADA: begin
          if (|int_m) begin
            state_d = S_ROBO;
          end else if (pw_err) begin
            if (intentos_q == IW'(MAX_INTENTOS - 1)) state_d = S_ROBO;
            else intentos_d = intentos_q + 1'b1;
          end else if (pw_ok_v) begin
            state_d = S_DESARMADO;
          end else if (cnt_q == '0) begin
            state_d = S_ROBO;
          end else begin
            cnt_d = cnt_q - 1'b1;
          end
        end
        S_ROBO: begin
          if (pw_ok_v) state_d = S_DESARMADO;
        end
        S_INCENDIO: begin
          if (pw_ok_v && !humo) state_d = S_DESARMADO;
        end
        default: state_d = S_DESARMADO;
      endcase
    end

    // Zones accumulate only while the intrusion path is active; fire holds them.
    if (state_d == S_DESARMADO) begin
      zona_d = '0;
    end else if ((state_q == S_ARMADO || state_q == S_ENTRADA || state_q == S_ROBO) &&
                 (state_d == S_ENTRADA || state_d == S_ROBO)) begin
      zona_d = zona_q | int_m | pta_m;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_DESARMADO;
      cnt_q      <= '0;
      intentos_q <= '0;
      zona_q     <= '0;
      incendio_q <= 1'b0;
      luces_q    <= 1'b0;
      robo_q     <= 1'b0;
      armado_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      intentos_q <= intentos_d;
      zona_q     <= zona_d;
      incendio_q <= (state_d == S_INCENDIO);
      robo_q     <= (state_d == S_ROBO);
      luces_q    <= (state_d == S_SALIDA) || (state_d == S_ENTRADA) ||
                    (state_d == S_ROBO)   || (state_d == S_INCENDIO);
      armado_q   <= (state_d == S_ARMADO) || (state_d == S_ENTRADA);
    end
  end

  assign alarma_incendio = incendio_q;
  assign luces           = luces_q;
  assign alarma_robo     = robo_q;
  assign armado          = armado_q;
  assign zona_disparo    = zona_q;
  assign estado          = state_q;

endmodule

// File: tb/tb_alarma_multizona.sv
// Bench for alarma_multizona: directed scenarios with fixed expectations plus
// randomized traffic checked against a cycle-level behavioural model.
module tb_alarma_multizona;

  localparam int N  = 4;
  localparam int TS = 8;
  localparam int TE = 16;
  localparam int MI = 2;

  localparam logic [2:0] C_DES = 3'b000, C_SAL = 3'b101, C_ARM = 3'b111,
                         C_ENT = 3'b011, C_ROB = 3'b010, C_INC = 3'b001;

  logic         clk = 1'b0;
  logic         rst, humo, armar, pw_ok, pw_err;
  logic [N-1:0] zona_mask, sens_int, sens_puerta;
  logic         alarma_incendio, luces, alarma_robo, armado;
  logic [N-1:0] zona_disparo;
  logic [2:0]   estado;

  int n_checks = 0;
  int n_fail   = 0;

  // behavioural model: state name, cycles already spent in a timed state,
  // errors counted in the current entry, zones recorded
  logic [2:0]   m_st;
  int           m_spent;
  int           m_errs;
  logic [N-1:0] m_zona;

  alarma_multizona #(.N_ZONAS(N), .T_SALIDA(TS), .T_ENTRADA(TE), .MAX_INTENTOS(MI)) dut (
    .clk(clk), .rst(rst), .humo(humo), .armar(armar), .pw_ok(pw_ok), .pw_err(pw_err),
    .zona_mask(zona_mask), .sens_int(sens_int), .sens_puerta(sens_puerta),
    .alarma_incendio(alarma_incendio), .luces(luces), .alarma_robo(alarma_robo),
    .armado(armado), .zona_disparo(zona_disparo), .estado(estado)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_st = C_DES; m_spent = 0; m_errs = 0; m_zona = '0;
  endtask

  task automatic model_step();
    logic [N-1:0] im, pm;
    logic [2:0]   nx;
    bit           ok;
    im = sens_int & zona_mask;
    pm = sens_puerta & zona_mask;
    ok = pw_ok && !pw_err;
    nx = m_st;
    if (humo && m_st != C_INC) nx = C_INC;
    else if (m_st == C_DES) begin
      if (armar) begin nx = C_SAL; m_spent = 0; end
    end else if (m_st == C_SAL) begin
      m_spent++;
      if (ok) nx = C_DES;
      else if (m_spent >= TS) nx = C_ARM;
    end else if (m_st == C_ARM) begin
      if (im != 0) nx = C_ROB;
      else if (pm != 0) begin nx = C_ENT; m_spent = 0; m_errs = 0; end
    end else if (m_st == C_ENT) begin
      if (im != 0) nx = C_ROB;
      else if (pw_err) begin
        m_errs++;
        if (m_errs >= MI) nx = C_ROB;
      end else if (ok) nx = C_DES;
      else begin
        m_spent++;
        if (m_spent >= TE) nx = C_ROB;
      end
    end else if (m_st == C_ROB) begin
      if (ok) nx = C_DES;
    end else if (m_st == C_INC) begin
      if (ok && !humo) nx = C_DES;
    end
    if (nx == C_DES) m_zona = '0;
    else if ((m_st == C_ARM || m_st == C_ENT || m_st == C_ROB) && (nx == C_ENT || nx == C_ROB))
      m_zona = m_zona | im | pm;
    m_st = nx;
  endtask

  task automatic cyc();
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    #1;
  endtask

  task automatic clear_inputs();
    humo = 0; armar = 0; pw_ok = 0; pw_err = 0;
    sens_int = '0; sens_puerta = '0;
  endtask

  task automatic arm_system(input logic [N-1:0] mask);
    zona_mask = mask;
    armar = 1; cyc(); armar = 0;
    repeat (TS) cyc();
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); zona_mask = '1;
    model_reset();
    cyc(); cyc();
    rst = 0;
    cyc();
    n_checks++; if (estado !== C_DES) begin n_fail++; $display("FAIL reset_estado got %b want %b", estado, C_DES); end
    n_checks++; if ({alarma_incendio, luces, alarma_robo, armado} !== 4'b0) begin n_fail++;
      $display("FAIL reset_outputs got %b want 0000", {alarma_incendio, luces, alarma_robo, armado}); end
    n_checks++; if (zona_disparo !== '0) begin n_fail++; $display("FAIL reset_zona got %b want 0", zona_disparo); end
  endtask

  task automatic test_arm();
    zona_mask = '1;
    armar = 1; cyc(); armar = 0;
    for (int i = 0; i < TS; i++) begin
      n_checks++; if (estado !== C_SAL || luces !== 1'b1 || armado !== 1'b0) begin n_fail++;
        $display("FAIL arm_salida cycle %0d got estado %b luces %b want %b 1", i, estado, luces, C_SAL); end
      cyc();
    end
    n_checks++; if (estado !== C_ARM || armado !== 1'b1 || luces !== 1'b0) begin n_fail++;
      $display("FAIL arm_done got estado %b armado %b luces %b want 111 1 0", estado, armado, luces); end
  endtask

  task automatic test_entry_disarm();
    sens_puerta = 4'b0100; cyc(); sens_puerta = '0;
    n_checks++; if (estado !== C_ENT || zona_disparo !== 4'b0100 || armado !== 1'b1 || luces !== 1'b1) begin n_fail++;
      $display("FAIL entry_start got estado %b zona %b want 011 0100", estado, zona_disparo); end
    repeat (4) cyc();
    n_checks++; if (estado !== C_ENT || zona_disparo !== 4'b0100) begin n_fail++;
      $display("FAIL entry_hold got estado %b zona %b want 011 0100", estado, zona_disparo); end
    pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_DES || zona_disparo !== '0 || luces !== 1'b0) begin n_fail++;
      $display("FAIL entry_disarm got estado %b zona %b want 000 0000", estado, zona_disparo); end
  endtask

  task automatic test_entry_timeout();
    arm_system('1);
    sens_puerta = 4'b0001; cyc(); sens_puerta = '0;
    for (int i = 1; i < TE; i++) begin
      n_checks++; if (estado !== C_ENT || alarma_robo !== 1'b0) begin n_fail++;
        $display("FAIL timeout_wait cycle %0d got estado %b robo %b want 011 0", i, estado, alarma_robo); end
      cyc();
    end
    n_checks++; if (estado !== C_ENT) begin n_fail++; $display("FAIL timeout_last got %b want 011", estado); end
    cyc();
    n_checks++; if (estado !== C_ROB || alarma_robo !== 1'b1 || zona_disparo !== 4'b0001) begin n_fail++;
      $display("FAIL timeout_robo got estado %b robo %b zona %b want 010 1 0001", estado, alarma_robo, zona_disparo); end
    pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_DES) begin n_fail++; $display("FAIL robo_disarm got %b want 000", estado); end
  endtask

  task automatic test_last_cycle_disarm();
    arm_system('1);
    sens_puerta = 4'b0010; cyc(); sens_puerta = '0;
    repeat (TE - 1) cyc();
    pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_DES) begin n_fail++; $display("FAIL last_cycle_pwok got %b want 000", estado); end
  endtask

  task automatic test_attempts();
    arm_system('1);
    sens_puerta = 4'b0010; cyc(); sens_puerta = '0;
    pw_err = 1; cyc(); pw_err = 0;
    n_checks++; if (estado !== C_ENT) begin n_fail++; $display("FAIL attempt_first got %b want 011", estado); end
    cyc();
    pw_err = 1; pw_ok = 1; cyc(); pw_err = 0; pw_ok = 0;
    n_checks++; if (estado !== C_ROB || alarma_robo !== 1'b1) begin n_fail++;
      $display("FAIL attempt_second got estado %b robo %b want 010 1", estado, alarma_robo); end
    pw_ok = 1; pw_err = 1; cyc(); pw_err = 0; pw_ok = 0;
    n_checks++; if (estado !== C_ROB) begin n_fail++; $display("FAIL robo_okerr got %b want 010", estado); end
    pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_DES) begin n_fail++; $display("FAIL attempt_clear got %b want 000", estado); end
  endtask

  task automatic test_masking_fire();
    arm_system(4'b1110);
    sens_int = 4'b0001;
    repeat (3) cyc();
    n_checks++; if (estado !== C_ARM) begin n_fail++; $display("FAIL mask_ignore got %b want 111", estado); end
    sens_int = 4'b1000; cyc(); sens_int = '0;
    n_checks++; if (estado !== C_ROB || zona_disparo !== 4'b1000) begin n_fail++;
      $display("FAIL mask_robo got estado %b zona %b want 010 1000", estado, zona_disparo); end
    humo = 1; cyc();
    n_checks++; if (estado !== C_INC || alarma_incendio !== 1'b1 || luces !== 1'b1 || alarma_robo !== 1'b0) begin n_fail++;
      $display("FAIL fire_enter got estado %b inc %b luces %b robo %b want 001 1 1 0", estado, alarma_incendio, luces, alarma_robo); end
    n_checks++; if (zona_disparo !== 4'b1000) begin n_fail++; $display("FAIL fire_zona_hold got %b want 1000", zona_disparo); end
    pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_INC) begin n_fail++; $display("FAIL fire_pwok_smoke got %b want 001", estado); end
    humo = 0; pw_ok = 1; cyc(); pw_ok = 0;
    n_checks++; if (estado !== C_DES || alarma_incendio !== 1'b0 || zona_disparo !== '0) begin n_fail++;
      $display("FAIL fire_clear got estado %b inc %b zona %b want 000 0 0", estado, alarma_incendio, zona_disparo); end
  endtask

  task automatic test_reset_mid_salida();
    zona_mask = '1;
    armar = 1; cyc(); armar = 0; cyc(); cyc();
    #2 rst = 1; #1;
    n_checks++; if (estado !== C_DES || {alarma_incendio, luces, alarma_robo, armado} !== 4'b0) begin n_fail++;
      $display("FAIL async_reset got estado %b outs %b want 000 0000", estado, {alarma_incendio, luces, alarma_robo, armado}); end
    model_reset();
    cyc(); rst = 0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if (i % 400 == 0) zona_mask = N'($urandom);
      rst    = ($urandom_range(0, 799) == 0);
      humo   = ($urandom_range(0, 79) == 0) || (humo && $urandom_range(0, 3) != 0);
      armar  = ($urandom_range(0, 7) == 0);
      pw_ok  = ($urandom_range(0, 19) == 0);
      pw_err = ($urandom_range(0, 29) == 0);
      for (int b = 0; b < N; b++) begin
        sens_int[b]    = ($urandom_range(0, 59) == 0);
        sens_puerta[b] = ($urandom_range(0, 19) == 0);
      end
      cyc();
      n_checks++; if (estado !== m_st || zona_disparo !== m_zona) begin n_fail++;
        $display("FAIL rand_state it %0d got estado %b zona %b want %b %b", i, estado, zona_disparo, m_st, m_zona); end
      n_checks++; if (alarma_incendio !== (m_st == C_INC) || alarma_robo !== (m_st == C_ROB) ||
                      armado !== (m_st == C_ARM || m_st == C_ENT) ||
                      luces !== (m_st == C_SAL || m_st == C_ENT || m_st == C_ROB || m_st == C_INC)) begin n_fail++;
        $display("FAIL rand_outputs it %0d got inc %b luces %b robo %b armado %b for state %b", i,
                 alarma_incendio, luces, alarma_robo, armado, m_st); end
    end
    clear_inputs(); rst = 0;
  endtask

  initial begin
    test_reset();
    test_arm();
    test_entry_disarm();
    test_entry_timeout();
    test_last_cycle_disarm();
    test_attempts();
    test_masking_fire();
    test_reset_mid_salida();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
